wb_slave_arbiter: RTL and testbench
===================================

Name: wb_slave_arbiter

Overview:
Per-slave two-master Wishbone B4 arbiter. One instance sits in front of each slave port of the crossbar and decides which master owns that slave. Grant is round-robin and is held for a full CYC burst. Slave responses are routed back only to the granted master. An optional watchdog aborts transfers to a slave that never responds.

Parameters:
AW, 32, address width
DW, 32, data width
SW, 4, byte-select width (DW/8)
TIMEOUT_CYCLES, 256, stalled-strobe cycles before abort (only used with timeout feature; legal range 2..65535)

Ports:
clk  in  1  system clock, shared by all masters and slaves
rst  in  1  synchronous active-low reset
m0_hit, m1_hit  in  1  master address decodes to this slave (from crossbar decoder)
m0_cyc, m1_cyc  in  1  master CYC
m0_stb, m1_stb  in  1  master STB
m0_we, m1_we  in  1  master WE
m0_adr, m1_adr  in  AW  master ADR
m0_dat_w, m1_dat_w  in  DW  master write data
m0_sel, m1_sel  in  SW  master SEL
m0_ack, m1_ack  out  1  ACK to master
m0_err, m1_err  out  1  ERR to master
m0_stall, m1_stall  out  1  master must hold request
m_dat_r  out  DW  slave read data, broadcast to both masters
s_cyc, s_stb, s_we  out  1  slave-side control
s_adr  out  AW  slave-side address
s_dat_w  out  DW  slave-side write data
s_sel  out  SW  slave-side byte select
s_ack, s_err  in  1  slave response
s_dat_r  in  DW  slave read data
gnt  out  2  one-hot grant, bit i = master i owns slave
busy  out  1  gnt != 0

Behaviour:
- Requests: req_i = mi_cyc & mi_hit.
- States:
  - IDLE: gnt=00.
  - G0: gnt=01.
  - G1: gnt=10.
  - ABORT: timeout build only.
- Registered pointer `last`: records the most recently granted master. Reset value 1, so master 0 wins the first tie.
- IDLE transitions:
  - Only req_0 → G0.
  - Only req_1 → G1.
  - Both → grant the master != last.
  - Neither → stay IDLE.
- Request-to-grant latency is 1 cycle. While IDLE, all s_* outputs are 0.
- Gx hold: stay in Gx while req_x = 1. Grant is never preempted mid-burst.
- Gx release (req_x drops): next state is Gy if req_y = 1 (zero-bubble handoff), else IDLE. `last` is updated on entry to any Gx.
- Output muxing in Gx (combinational from granted master):
  - s_cyc = mx_cyc.
  - s_stb = mx_stb.
  - s_we, s_adr, s_dat_w, s_sel = master x.
  - mx_ack = s_ack, mx_err = s_err.
  - m_dat_r = s_dat_r in every state.
- Non-granted master: ack = err = 0; stall = 1 whenever its req is 1. The granted master has stall = 0.
- Simultaneous release of x and arrival of y: handoff to y next cycle, as above. Never two bits set in gnt.
- ACK/ERR arriving in a cycle where no grant is active is dropped and reaches no master.
- Reset (rst = 0 at a clock edge), at any time including mid-burst:
  - state = IDLE, gnt = 00, busy = 0, last = 1.
  - All s_* outputs and mi_ack/err/stall = 0 on the next cycle.
  - Watchdog counter = 0.
- Pipelined Wishbone is passed through unchanged. The arbiter does not count outstanding STBs; the master is responsible for holding CYC until all ACKs return.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- With macro, a 16-bit counter `wd`:
  - Cleared when not in Gx, when s_stb = 0, or when s_ack | s_err.
  - Otherwise increments each cycle.
- When wd reaches TIMEOUT_CYCLES-1 with no response in that cycle:
  - Next cycle: state = ABORT, mx_err = 1 for exactly one cycle (the first ABORT cycle), s_cyc = s_stb = 0.
  - ABORT holds until req_x drops, then follows the normal Gx release rules.
- Without macro: no counter, no ABORT state; a hung slave holds the grant indefinitely.

Test Plan:
1. Reset with both masters idle → gnt=00, busy=0, s_cyc=0. Then m0 requests only (hit=1, cyc=stb=1) → gnt=01 one cycle later; s_adr = m0_adr; single s_ack routed to m0_ack only.
2. m0 and m1 request in the same cycle after reset → gnt=01 first. m0 drops cyc after 3 ACKs → gnt=10 on the next cycle with no IDLE bubble. Repeat the tie → gnt=10 first (round-robin).
3. m1 requests while m0 holds a 5-beat burst → m1_stall=1 and m1_ack=0 for all 5 beats. m0 is never preempted; gnt=10 follows release.
4. rst=0 asserted mid-burst on gnt=01 → next cycle gnt=00 and all outputs 0. After rst returns high with both masters requesting → master 0 granted first.
5. Slave returns s_err=1 → routed to m0_err only. Read data 32'hDEADBEEF appears on m_dat_r with s_ack.
6. WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks → m0_err=1 exactly once on cycle 5 of STB; s_cyc=0 while m0 holds cyc. m0 drops cyc → IDLE. Without the macro, the same stimulus holds gnt=01 for 1000 cycles.

Source files
------------

// File: rtl/wb_slave_arbiter.sv
// Two-master round-robin Wishbone B4 arbiter placed in front of one crossbar slave port.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that aborts transfers to a slave that never responds.
module wb_slave_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int SW             = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_hit,
  input  logic          m1_hit,
  input  logic          m0_cyc,
  input  logic          m1_cyc,
  input  logic          m0_stb,
  input  logic          m1_stb,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_adr,
  input  logic [AW-1:0] m1_adr,
  input  logic [DW-1:0] m0_dat_w,
  input  logic [DW-1:0] m1_dat_w,
  input  logic [SW-1:0] m0_sel,
  input  logic [SW-1:0] m1_sel,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic          m0_err,
  output logic          m1_err,
  output logic          m0_stall,
  output logic          m1_stall,
  output logic [DW-1:0] m_dat_r,
  output logic          s_cyc,
  output logic          s_stb,
  output logic          s_we,
  output logic [AW-1:0] s_adr,
  output logic [DW-1:0] s_dat_w,
  output logic [SW-1:0] s_sel,
  input  logic          s_ack,
  input  logic          s_err,
  input  logic [DW-1:0] s_dat_r,
  output logic [1:0]    gnt,
  output logic          busy
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wb_slave_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

`ifdef WB_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, G0, G1, ABORT} state_t;
`else
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
`endif

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   w_req0;
  logic   w_req1;
  logic   w_own0;
  logic   w_own1;

  assign w_req0 = m0_cyc & m0_hit;
  assign w_req1 = m1_cyc & m1_hit;

`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] r_wd;
  logic        r_ab_first;
  logic        w_in_g;
  logic        w_wd_run;
  logic        w_timeout;

  assign w_in_g    = (r_state == G0) || (r_state == G1);
  assign w_wd_run  = w_in_g && s_stb && !(s_ack || s_err);
  assign w_timeout = w_wd_run && (r_wd == WD_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wd       <= '0;
      r_ab_first <= 1'b0;
    end else begin
      r_wd       <= w_wd_run ? r_wd + 16'd1 : '0;
      r_ab_first <= (r_state != ABORT) && (w_next == ABORT);
    end
  end

  // In ABORT the owner is the master recorded in r_last.
  assign w_own0 = (r_state == G0) || ((r_state == ABORT) && !r_last);
  assign w_own1 = (r_state == G1) || ((r_state == ABORT) && r_last);
`else
  assign w_own0 = (r_state == G0);
  assign w_own1 = (r_state == G1);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_next;
      if (w_next == G0)
        r_last <= 1'b0;
      else if (w_next == G1)
        r_last <= 1'b1;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req0 && w_req1)
          w_next = r_last ? G0 : G1;
        else if (w_req0)
          w_next = G0;
        else if (w_req1)
          w_next = G1;
      end
      G0: begin
        if (w_req0) begin
          w_next = G0;
`ifdef WB_ARB_TIMEOUT_EN
          if (w_timeout) w_next = ABORT;
`endif
        end else begin
          w_next = w_req1 ? G1 : IDLE;
        end
      end
      G1: begin
        if (w_req1) begin
          w_next = G1;
`ifdef WB_ARB_TIMEOUT_EN
          if (w_timeout) w_next = ABORT;
`endif
        end else begin
          w_next = w_req0 ? G0 : IDLE;
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      ABORT: begin
        if (r_last ? w_req1 : w_req0)
          w_next = ABORT;
        else if (r_last ? w_req0 : w_req1)
          w_next = r_last ? G0 : G1;
        else
          w_next = IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = '0;
    s_dat_w = '0;
    s_sel   = '0;
    m0_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_ack  = 1'b0;
    m1_err  = 1'b0;
    if (r_state == G0) begin
      s_cyc   = m0_cyc;
      s_stb   = m0_stb;
      s_we    = m0_we;
      s_adr   = m0_adr;
      s_dat_w = m0_dat_w;
      s_sel   = m0_sel;
      m0_ack  = s_ack;
      m0_err  = s_err;
    end else if (r_state == G1) begin
      s_cyc   = m1_cyc;
      s_stb   = m1_stb;
      s_we    = m1_we;
      s_adr   = m1_adr;
      s_dat_w = m1_dat_w;
      s_sel   = m1_sel;
      m1_ack  = s_ack;
      m1_err  = s_err;
    end
`ifdef WB_ARB_TIMEOUT_EN
    else if (r_state == ABORT) begin
      m0_err = !r_last && r_ab_first;
      m1_err = r_last && r_ab_first;
    end
`endif
  end

  // Stall is held low while reset is asserted so masters see a quiet port.
  assign m0_stall = rst & w_req0 & ~w_own0;
  assign m1_stall = rst & w_req1 & ~w_own1;
  assign m_dat_r  = s_dat_r;
  assign gnt      = {w_own1, w_own0};
  assign busy     = w_own0 | w_own1;

endmodule

// File: tb/tb_wb_slave_arbiter.sv
// Directed self-checking bench for wb_slave_arbiter (TIMEOUT_CYCLES=4; watchdog path checked when WB_ARB_TIMEOUT_EN is defined).
module tb_wb_slave_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  localparam logic [AW-1:0] A0 = 32'h1000_0010;
  localparam logic [AW-1:0] A1 = 32'h2000_0020;
  localparam logic [DW-1:0] D0 = 32'hA5A5_0001;
  localparam logic [DW-1:0] D1 = 32'h5A5A_0002;

  logic          clk;
  logic          rst;
  logic          m0_hit, m1_hit, m0_cyc, m1_cyc, m0_stb, m1_stb, m0_we, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [DW-1:0] m0_dat_w, m1_dat_w;
  logic [SW-1:0] m0_sel, m1_sel;
  logic          m0_ack, m1_ack, m0_err, m1_err, m0_stall, m1_stall;
  logic [DW-1:0] m_dat_r;
  logic          s_cyc, s_stb, s_we;
  logic [AW-1:0] s_adr;
  logic [DW-1:0] s_dat_w;
  logic [SW-1:0] s_sel;
  logic          s_ack, s_err;
  logic [DW-1:0] s_dat_r;
  logic [1:0]    gnt;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  wb_slave_arbiter #(.AW(AW), .DW(DW), .SW(SW), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .m0_hit(m0_hit), .m1_hit(m1_hit), .m0_cyc(m0_cyc), .m1_cyc(m1_cyc),
    .m0_stb(m0_stb), .m1_stb(m1_stb), .m0_we(m0_we), .m1_we(m1_we),
    .m0_adr(m0_adr), .m1_adr(m1_adr), .m0_dat_w(m0_dat_w), .m1_dat_w(m1_dat_w),
    .m0_sel(m0_sel), .m1_sel(m1_sel),
    .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_err(m0_err), .m1_err(m1_err),
    .m0_stall(m0_stall), .m1_stall(m1_stall), .m_dat_r(m_dat_r),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
    .s_dat_w(s_dat_w), .s_sel(s_sel), .s_ack(s_ack), .s_err(s_err),
    .s_dat_r(s_dat_r), .gnt(gnt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #2;
  endtask

  task automatic setm0(input logic hit, input logic cyc, input logic stb);
    m0_hit = hit; m0_cyc = cyc; m0_stb = stb;
  endtask

  task automatic setm1(input logic hit, input logic cyc, input logic stb);
    m1_hit = hit; m1_cyc = cyc; m1_stb = stb;
  endtask

  initial begin
    #100000;
    $display("FAIL sim_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic held_ok;
    rst = 1'b0;
    setm0(0, 0, 0); setm1(0, 0, 0);
    m0_we = 1'b1; m1_we = 1'b0;
    m0_adr = A0; m1_adr = A1; m0_dat_w = D0; m1_dat_w = D1;
    m0_sel = 4'hF; m1_sel = 4'h3;
    s_ack = 1'b0; s_err = 1'b0; s_dat_r = '0;

    // Test 1: reset state, single request from m0
    nxt; nxt;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_s_cyc", s_cyc, 1'b0);
    setm0(1, 1, 1);
    #1 chk("rst_m0_stall", m0_stall, 1'b0);
    rst = 1'b1;
    #1 chk("idle_m0_stall", m0_stall, 1'b1);
    chk("idle_s_stb", s_stb, 1'b0);
    chk("latency_gnt", gnt, 2'b00);
    nxt;
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_busy", busy, 1'b1);
    chk("t1_s_adr", s_adr, A0);
    chk("t1_s_dat_w", s_dat_w, D0);
    chk("t1_s_sel", s_sel, 4'hF);
    chk("t1_s_we", s_we, 1'b1);
    chk("t1_s_cyc", s_cyc, 1'b1);
    chk("t1_m0_stall", m0_stall, 1'b0);
    s_ack = 1'b1;
    #1 chk("t1_m0_ack", m0_ack, 1'b1);
    chk("t1_m1_ack", m1_ack, 1'b0);
    nxt;
    s_ack = 1'b0; setm0(0, 0, 0);
    #1 chk("t1_m0_ack_clear", m0_ack, 1'b0);
    chk("t1_gnt_hold", gnt, 2'b01);
    nxt;
    chk("t1_idle_gnt", gnt, 2'b00);

    // Test 2: tie after reset, zero-bubble handoff, round-robin
    rst = 1'b0; nxt; rst = 1'b1;
    setm0(1, 1, 1); setm1(1, 1, 1);
    #1 chk("t2_m1_stall_idle", m1_stall, 1'b1);
    nxt;
    chk("t2_tie_gnt", gnt, 2'b01);
    chk("t2_s_adr", s_adr, A0);
    chk("t2_m1_stall", m1_stall, 1'b1);
    chk("t2_m0_stall", m0_stall, 1'b0);
    s_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t2_m0_ack", m0_ack, 1'b1);
      chk("t2_m1_ack", m1_ack, 1'b0);
      nxt;
    end
    s_ack = 1'b0; setm0(0, 0, 0);
    #1 chk("t2_gnt_release_cycle", gnt, 2'b01);
    chk("t2_s_cyc_follows", s_cyc, 1'b0);
    nxt;
    chk("t2_handoff_gnt", gnt, 2'b10);
    chk("t2_handoff_s_adr", s_adr, A1);
    chk("t2_handoff_s_sel", s_sel, 4'h3);
    chk("t2_m1_stall_gnt", m1_stall, 1'b0);
    setm1(0, 0, 0);
    nxt;
    chk("t2_idle_gnt", gnt, 2'b00);
    setm0(1, 1, 1);
    nxt;
    chk("t2_m0_alone_gnt", gnt, 2'b01);
    setm0(0, 0, 0);
    nxt;
    setm0(1, 1, 1); setm1(1, 1, 1);
    nxt;
    chk("t2_rr_tie_gnt", gnt, 2'b10);
    setm1(0, 0, 0);
    nxt;
    chk("t2_rr_handoff_gnt", gnt, 2'b01);
    setm0(0, 0, 0);
    nxt;
    chk("t2_rr_idle_gnt", gnt, 2'b00);

    // Test 3: m1 waits out a 5-beat burst from m0
    setm0(1, 1, 1);
    nxt;
    chk("t3_gnt", gnt, 2'b01);
    setm1(1, 1, 1); s_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1 chk("t3_m1_stall", m1_stall, 1'b1);
      chk("t3_m1_ack", m1_ack, 1'b0);
      chk("t3_m0_ack", m0_ack, 1'b1);
      chk("t3_gnt_hold", gnt, 2'b01);
      nxt;
    end
    s_ack = 1'b0; setm0(0, 0, 0);
    nxt;
    chk("t3_after_gnt", gnt, 2'b10);
    setm1(0, 0, 0);
    nxt;
    chk("t3_idle_gnt", gnt, 2'b00);

    // Test 4: reset mid-burst
    setm0(1, 1, 1);
    nxt;
    chk("t4_gnt", gnt, 2'b01);
    setm1(1, 1, 1); s_ack = 1'b1; rst = 1'b0;
    nxt;
    chk("t4_rst_gnt", gnt, 2'b00);
    chk("t4_rst_busy", busy, 1'b0);
    chk("t4_rst_s_cyc", s_cyc, 1'b0);
    chk("t4_rst_s_stb", s_stb, 1'b0);
    chk("t4_rst_s_adr", s_adr, 32'h0);
    chk("t4_rst_m0_ack", m0_ack, 1'b0);
    chk("t4_rst_m0_stall", m0_stall, 1'b0);
    chk("t4_rst_m1_stall", m1_stall, 1'b0);
    rst = 1'b1; s_ack = 1'b0;
    nxt;
    chk("t4_post_rst_gnt", gnt, 2'b01);

    // Test 5: error routing and read data
    s_err = 1'b1;
    #1 chk("t5_m0_err", m0_err, 1'b1);
    chk("t5_m1_err", m1_err, 1'b0);
    chk("t5_m0_ack", m0_ack, 1'b0);
    nxt;
    s_err = 1'b0; s_ack = 1'b1; s_dat_r = 32'hDEADBEEF;
    #1 chk("t5_m_dat_r", m_dat_r, 32'hDEADBEEF);
    chk("t5_m0_ack_rd", m0_ack, 1'b1);
    chk("t5_m1_ack_rd", m1_ack, 1'b0);
    nxt;
    s_ack = 1'b0; setm0(0, 0, 0); setm1(0, 0, 0);
    nxt;
    chk("t5_idle_gnt", gnt, 2'b00);
    s_ack = 1'b1;
    #1 chk("t5_idle_m0_ack_drop", m0_ack, 1'b0);
    chk("t5_idle_m1_ack_drop", m1_ack, 1'b0);
    s_ack = 1'b0;

    // Test 6: slave never responds
    setm0(1, 1, 1);
    nxt;
`ifdef WB_ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      #1 chk("t6_pre_m0_err", m0_err, 1'b0);
      chk("t6_pre_s_cyc", s_cyc, 1'b1);
      nxt;
    end
    #1 chk("t6_abort_m0_err", m0_err, 1'b1);
    chk("t6_abort_m1_err", m1_err, 1'b0);
    chk("t6_abort_s_cyc", s_cyc, 1'b0);
    chk("t6_abort_s_stb", s_stb, 1'b0);
    chk("t6_abort_gnt", gnt, 2'b01);
    nxt;
    chk("t6_abort_err_once", m0_err, 1'b0);
    chk("t6_abort_s_cyc_hold", s_cyc, 1'b0);
    setm0(0, 0, 0);
    nxt;
    chk("t6_release_gnt", gnt, 2'b00);
`else
    held_ok = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (gnt !== 2'b01 || m0_err !== 1'b0 || s_cyc !== 1'b1) held_ok = 1'b0;
      nxt;
    end
    chk("t6_hold_1000", held_ok, 1'b1);
    setm0(0, 0, 0);
    nxt;
    chk("t6_release_gnt", gnt, 2'b00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
